// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, keeps one instruction-memory
// request in flight at a time, and buffers the returned instruction in a
// single-entry output register drained with a valid/allow-in handshake.
// A redirect flushes wrong-path work and restarts fetch at the new PC.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a misaligned PC is not fetched; a fetch-exception marker
//               (inst = nop, fetch_exc = 1) is buffered and fetch halts
//               until the next redirect.
//   undefined : the address is word-aligned, fetch_exc is tied low and
//               there is no halt state.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | ready to issue a request at pc (when the buffer can accept)
// WAIT  | request granted, waiting for the response
// HALT  | misaligned PC reported, idle until redirect (macro only)
module ifu_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        out_allow,
  output logic        validout,
  output logic [31:0] inst,
  output logic [63:0] pc_out,
  output logic        fetch_exc
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic {ST_REQ = 1'b0, ST_WAIT = 1'b1} state_t;
`endif

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        buf_free;

`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_exc_q, fetch_exc_d;
  logic        misaligned;
  assign misaligned = (pc_q[1:0] != 2'b00);
  // A misaligned PC is never sent to memory.
  assign imem_req  = !rst && (state_q == ST_REQ) && buf_free && !misaligned;
  assign imem_addr = pc_q;
  assign fetch_exc = fetch_exc_q;
`else
  assign imem_req  = !rst && (state_q == ST_REQ) && buf_free;
  assign imem_addr = {pc_q[63:2], 2'b00};
  assign fetch_exc = 1'b0;
`endif

  // The buffer can take a new entry if empty or being drained this cycle.
  assign buf_free = !buf_valid_q || out_allow;
  assign validout = buf_valid_q && !redirect_valid;
  assign inst     = inst_q;
  assign pc_out   = pc_out_q;

  // Next-state logic: fetch FSM, output buffer and redirect handling.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
`ifdef IFU_MISALIGN_CHECK_EN
    fetch_exc_d = fetch_exc_q;
`endif

    if (validout && out_allow) buf_valid_d = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = ST_WAIT;
          // The request just granted belongs to the old path.
          if (redirect_valid) discard_d = 1'b1;
        end
`ifdef IFU_MISALIGN_CHECK_EN
        else if (misaligned && buf_free && !redirect_valid) begin
          buf_valid_d = 1'b1;
          inst_d      = 32'h0000_0013;
          pc_out_d    = pc_q;
          fetch_exc_d = 1'b1;
          state_d     = ST_HALT;
        end
`endif
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (!discard_q && !redirect_valid) begin
            buf_valid_d = 1'b1;
            inst_d      = imem_rdata;
            pc_out_d    = req_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
            fetch_exc_d = 1'b0;
`endif
          end
          discard_d = 1'b0;
          state_d   = ST_REQ;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      ST_HALT: begin
        if (redirect_valid) state_d = ST_REQ;
      end
`endif
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides sequential PC advance and flushes the buffer.
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      buf_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= 64'd0;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      inst_q      <= 32'd0;
      pc_out_q    <= 64'd0;
`ifdef IFU_MISALIGN_CHECK_EN
      fetch_exc_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
`ifdef IFU_MISALIGN_CHECK_EN
      fetch_exc_q <= fetch_exc_d;
`endif
    end
  end

endmodule
